// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; DIV_ZERO_EN adds a div_zero flag and a short path for divisor 0.
// Latency: done is high in the cycle after the 17th edge following accept (18 edges counting accept); 1 edge after accept for divisor 0 with DIV_ZERO_EN.
// No backpressure: start is sampled only in WAIT and ignored while busy, so nothing queues.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
`ifdef DIV_ZERO_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_SETUP   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             last_iter;
  logic             dvsr_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

`ifdef DIV_ZERO_EN
  assign dvsr_zero = (dvsr_q == '0);
`else
  assign dvsr_zero = 1'b0;
`endif

  // Partial remainder is kept WIDTH+1 bits wide after the shift so divisors
  // with the MSB set cannot overflow it; trial[WIDTH] is the borrow.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:    if (start) state_d = S_SETUP;
      S_SETUP:   state_d = dvsr_zero ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (last_iter) state_d = S_DONE;
      S_DONE:    state_d = S_WAIT;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    state = state_q;
    busy  = (state_q != S_WAIT);
    done  = (state_q == S_DONE);
  end

  always_comb begin
    dvnd_d = dvnd_q;
    dvsr_d = dvsr_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    quot_d = quot_q;
    rmdr_d = rmdr_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (start) begin
          dvnd_d = dividend;
          dvsr_d = divisor;
        end
      end
      S_SETUP: begin
        rem_d = '0;
        quo_d = dvnd_q;
        cnt_d = '0;
        if (dvsr_zero) begin
          quot_d = '1;
          rmdr_d = dvnd_q;
        end
      end
      S_COMPUTE: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNTW'(1);
        if (last_iter) begin
          quot_d = quo_step;
          rmdr_d = rem_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvnd_q <= '0;
      dvsr_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      quot_q <= '0;
      rmdr_q <= '0;
      cnt_q  <= '0;
    end else begin
      dvnd_q <= dvnd_d;
      dvsr_q <= dvsr_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      quot_q <= quot_d;
      rmdr_q <= rmdr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rmdr_q;

`ifdef DIV_ZERO_EN
  logic divz_q, divz_d;

  // Set on the SETUP->DONE shortcut, so it is high only for that DONE cycle.
  assign divz_d = (state_q == S_SETUP) && dvsr_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divz_q <= 1'b0;
    end else begin
      divz_q <= divz_d;
    end
  end

  assign div_zero = divz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: timeline/arithmetic reference model plus hand-computed literal checks.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic [1:0]   state;
  logic         busy, done;
`ifdef DIV_ZERO_EN
  logic         div_zero;
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .state    (state),
    .busy     (busy),
    .done     (done)
`ifdef DIV_ZERO_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies a fixed number of edges,
  // results follow from plain / and %.
  int           m_left = 0;
  int           m_len  = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;

  function automatic int op_len(input logic [W-1:0] b);
    return (DZ && b == '0) ? 2 : W + 2;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_len  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_a    <= dividend;
        m_b    <= divisor;
        m_len  <= op_len(divisor);
        m_left <= op_len(divisor);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_q <= (m_b == '0) ? '1 : m_a / m_b;
        m_r <= (m_b == '0) ? m_a : m_a % m_b;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] es;
    if (m_left == 0)          es = 2'd0;
    else if (m_left == 1)     es = 2'd3;
    else if (m_left == m_len) es = 2'd1;
    else                      es = 2'd2;
    chk("state", state, es);
    chk("busy", busy, m_left != 0);
    chk("done", done, m_left == 1);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
`ifdef DIV_ZERO_EN
    chk("div_zero", div_zero, (m_left == 1) && (m_b == '0));
`endif
  end

  // Accept one operation from WAIT and check latency and results against literals.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int elat, input string nm);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_quotient"}, quotient, eq);
    chk({nm, "_remainder"}, remainder, er);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] tbl_a [8] = '{16'd1000, 16'hFFFF, 16'h1234, 16'd7, 16'd3, 16'hABCD, 16'd0, 16'd50000};
  logic [W-1:0] tbl_b [8] = '{16'd10, 16'h8001, 16'h0000, 16'd7, 16'hFFFF, 16'h0012, 16'd5, 16'd250};

  initial begin
    int dones;
    int n;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(16'd100, 16'd7, 16'd14, 16'd2, 17, "d100_7");
    do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 17, "dffff_1");
    do_op(16'd5, 16'd9, 16'd0, 16'd5, 17, "d5_9");
    do_op(16'h8000, 16'h8000, 16'd1, 16'd0, 17, "d8000_8000");
    do_op(16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 17, "dffff_8001");
    do_op(16'h1234, 16'd0, 16'hFFFF, 16'h1234, DZ ? 1 : 17, "d1234_0");

    // start held high with operands changing every cycle
    @(negedge clk);
    dividend = tbl_a[0];
    divisor  = tbl_b[0];
    start    = 1'b1;
    dones    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      dividend = tbl_a[i % 8];
      divisor  = tbl_b[i % 8];
    end
    start = 1'b0;
    chk("b2b_done_count", dones, 2);
    n = 0;
    while (m_left != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_drained", m_left, 0);

    // start pulse during COMPUTE must not disturb the running operation
    @(negedge clk);
    dividend = 16'd5000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dividend = 16'd999;
    divisor  = 16'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ignore_quotient", quotient, 16'd1666);
    chk("ignore_remainder", remainder, 16'd2);
    @(posedge clk);
    #1;

    // asynchronous reset with the counter at 7
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(16'd100, 16'd7, 16'd14, 16'd2, 17, "post_rst_100_7");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
